// File: rtl/axil_gcd_driver_if.sv
// Operand/result streams, AXI4-lite master channels and busy flag of the GCD driver.
// master is the driver's view; slave is the view of whatever sits around it.
interface axil_gcd_driver_if;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;

    logic [63:0] m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    logic        busy;

    modport master (
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tuser, m_axis_tvalid,
        input  m_axis_tready,
        output m_axi_awaddr, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready,
        output busy
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tuser, m_axis_tvalid,
        output m_axis_tready,
        input  m_axi_awaddr, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready,
        input  busy
    );
endinterface

// File: rtl/axil_gcd_driver.sv
// Takes {B,A} operand pairs, drives a memory-mapped GCD slave over AXI4-lite
// (load A/B, start, poll READY, read R and CNT) and emits {CNT,R} with an error flag.
module axil_gcd_driver #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input logic               aclk,
    input logic               aresetn,
    axil_gcd_driver_if.master bus
);

    localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [3:0] {
        IDLE, WR_A, WR_B, WR_GO, GAP, POLL, RD_R, RD_CNT, OUT
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   a_q, a_d, b_q, b_d, r_q, r_d, cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic          arvalid_q, arvalid_d, rready_q, rready_d;
    logic          tvalid_q, tvalid_d, tready_q, tready_d, busy_q, busy_d;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0]   awaddr, wdata, araddr;

    assign aw_hs = awvalid_q & bus.m_axi_awready;
    assign w_hs  = wvalid_q  & bus.m_axi_wready;
    assign b_hs  = bready_q  & bus.m_axi_bvalid;
    assign ar_hs = arvalid_q & bus.m_axi_arready;
    assign r_hs  = rready_q  & bus.m_axi_rvalid;

    // Address/data depend only on state and latched operands, so they hold while valid is up.
    always_comb begin
        awaddr = BASE_ADDR;
        wdata  = 32'h1;
        araddr = BASE_ADDR;
        case (state_q)
            WR_A:    begin awaddr = BASE_ADDR + 32'h04; wdata = a_q; end
            WR_B:    begin awaddr = BASE_ADDR + 32'h08; wdata = b_q; end
            RD_R:    araddr = BASE_ADDR + 32'h0C;
            RD_CNT:  araddr = BASE_ADDR + 32'h10;
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        poll_d    = poll_q;
        gap_d     = gap_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        tvalid_d  = tvalid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.s_axis_tvalid && tready_q) begin
                    a_d       = bus.s_axis_tdata[31:0];
                    b_d       = bus.s_axis_tdata[63:32];
                    err_d     = 1'b0;
                    poll_d    = '0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WR_A;
                end
            end
            WR_A, WR_B, WR_GO: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                bready_d = ~awvalid_d & ~wvalid_d;
                if (b_hs) begin
                    bready_d = 1'b0;
                    if (bus.m_axi_bresp != 2'b00) err_d = 1'b1;
                    // Launching the next write here keeps exactly one transaction in flight.
                    case (state_q)
                        WR_A: begin
                            state_d   = WR_B;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                        end
                        WR_B: begin
                            state_d   = WR_GO;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                        end
                        default: begin
                            if (GAP_CYCLES == 0) begin
                                state_d   = POLL;
                                arvalid_d = 1'b1;
                            end else begin
                                state_d = GAP;
                                gap_d   = '0;
                            end
                        end
                    endcase
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d   = POLL;
                    arvalid_d = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            POLL, RD_R, RD_CNT: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
                if (r_hs) begin
                    rready_d = 1'b0;
                    if (bus.m_axi_rresp != 2'b00) err_d = 1'b1;
                    case (state_q)
                        POLL: begin
                            if (bus.m_axi_rdata[1]) begin
                                state_d   = RD_R;
                                arvalid_d = 1'b1;
                            end else begin
                                poll_d = poll_q + 1'b1;
                                if (poll_d == PW'(POLL_LIMIT)) begin
                                    r_d      = '0;
                                    cnt_d    = '1;
                                    err_d    = 1'b1;
                                    tvalid_d = 1'b1;
                                    state_d  = OUT;
                                end else begin
                                    arvalid_d = 1'b1;
                                end
                            end
                        end
                        RD_R: begin
                            r_d       = bus.m_axi_rdata;
                            state_d   = RD_CNT;
                            arvalid_d = 1'b1;
                        end
                        default: begin
                            cnt_d    = bus.m_axi_rdata;
                            tvalid_d = 1'b1;
                            state_d  = OUT;
                        end
                    endcase
                end
            end
            OUT: begin
                if (tvalid_q && bus.m_axis_tready) begin
                    tvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        tready_d = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            poll_q    <= '0;
            gap_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            tvalid_q  <= 1'b0;
            tready_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            poll_q    <= poll_d;
            gap_q     <= gap_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            tvalid_q  <= tvalid_d;
            tready_q  <= tready_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.s_axis_tready = tready_q;
    assign bus.m_axis_tdata  = {cnt_q, r_q};
    assign bus.m_axis_tuser  = err_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axi_awaddr  = awaddr;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata;
    assign bus.m_axi_wstrb   = 4'hF;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = araddr;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_axil_gcd_driver.sv
// Directed bench for axil_gcd_driver: a reactive GCD slave with programmable stalls,
// protocol monitors, and hand-computed expected results per job.
module tb_axil_gcd_driver;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int unsigned GAP   = 2;
    localparam int unsigned LIMIT = 4;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    axil_gcd_driver_if bus ();

    axil_gcd_driver #(
        .BASE_ADDR (BASE),
        .GAP_CYCLES(GAP),
        .POLL_LIMIT(LIMIT)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration
    int          aw_dly = 0, w_dly = 0, b_dly = 0;
    int          ready_after = 1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [1:0]  err_resp = 2'b00;

    // Slave state, logs and monitor counters
    logic        got_aw = 0, got_w = 0, armed = 0;
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ctrl_reads = 0;
    logic [31:0] aw_addr_l, w_data_l, reg_a, reg_b, reg_r, reg_cnt;
    logic [31:0] wr_addr[$], wr_data[$];
    int          stab_viol = 0, dup_viol = 0, bready_viol = 0, overlap_viol = 0;
    int          strb_viol = 0, stall_viol = 0, beats = 0;
    int          cyc = 0, t_go = 0, t_ar = 0;

    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] awaddr_s, wdata_s, araddr_s;
    logic        p_rst = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
    logic        p_arv = 0, p_arr = 0, p_tv = 0, p_tr = 0, p_tu = 0;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [63:0] p_tdata;

    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bvalid = 0; bus.m_axi_bresp = 0;
        bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0; bus.m_axi_rresp = 0;
        forever begin
            @(negedge aclk);
            aw_hs    = bus.m_axi_awvalid && bus.m_axi_awready;
            w_hs     = bus.m_axi_wvalid && bus.m_axi_wready;
            b_hs     = bus.m_axi_bvalid && bus.m_axi_bready;
            ar_hs    = bus.m_axi_arvalid && bus.m_axi_arready;
            r_hs     = bus.m_axi_rvalid && bus.m_axi_rready;
            awaddr_s = bus.m_axi_awaddr;
            wdata_s  = bus.m_axi_wdata;
            araddr_s = bus.m_axi_araddr;
            if (aresetn && p_rst) begin
                if (p_awv && !p_awr && (!bus.m_axi_awvalid || bus.m_axi_awaddr !== p_awaddr)) stab_viol++;
                if (p_wv && !p_wr && (!bus.m_axi_wvalid || bus.m_axi_wdata !== p_wdata)) stab_viol++;
                if (p_arv && !p_arr && (!bus.m_axi_arvalid || bus.m_axi_araddr !== p_araddr)) stab_viol++;
                if (p_tv && !p_tr && (!bus.m_axis_tvalid || bus.m_axis_tdata !== p_tdata ||
                                      bus.m_axis_tuser !== p_tu)) stab_viol++;
                if (bus.m_axi_awvalid && got_aw) dup_viol++;
                if (bus.m_axi_wvalid && got_w) dup_viol++;
                if (bus.m_axi_bready && !(got_aw && got_w)) bready_viol++;
                if ((bus.m_axi_arvalid || bus.m_axi_rready) &&
                    (bus.m_axi_awvalid || bus.m_axi_wvalid || bus.m_axi_bready)) overlap_viol++;
                if (w_hs && bus.m_axi_wstrb !== 4'hF) strb_viol++;
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) beats++;
            if (b_hs && aw_addr_l == BASE) begin t_go = cyc; armed = 1; end
            if (armed && bus.m_axi_arvalid) begin t_ar = cyc; armed = 0; end
            p_rst = aresetn;
            p_awv = bus.m_axi_awvalid; p_awr = bus.m_axi_awready; p_awaddr = bus.m_axi_awaddr;
            p_wv  = bus.m_axi_wvalid;  p_wr  = bus.m_axi_wready;  p_wdata  = bus.m_axi_wdata;
            p_arv = bus.m_axi_arvalid; p_arr = bus.m_axi_arready; p_araddr = bus.m_axi_araddr;
            p_tv  = bus.m_axis_tvalid; p_tr  = bus.m_axis_tready;
            p_tdata = bus.m_axis_tdata; p_tu = bus.m_axis_tuser;

            @(posedge aclk);
            #1;
            if (!aresetn) begin
                bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bvalid = 0;
                bus.m_axi_arready = 0; bus.m_axi_rvalid = 0;
                got_aw = 0; got_w = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
            end else begin
                if (aw_hs) begin
                    got_aw = 1; aw_addr_l = awaddr_s; bus.m_axi_awready = 0; aw_wait = 0;
                end else if (bus.m_axi_awvalid && !got_aw) begin
                    bus.m_axi_awready = (aw_wait >= aw_dly); aw_wait++;
                end
                if (w_hs) begin
                    got_w = 1; w_data_l = wdata_s; bus.m_axi_wready = 0; w_wait = 0;
                end else if (bus.m_axi_wvalid && !got_w) begin
                    bus.m_axi_wready = (w_wait >= w_dly); w_wait++;
                end
                if (b_hs) begin
                    bus.m_axi_bvalid = 0; got_aw = 0; got_w = 0; b_wait = 0;
                    wr_addr.push_back(aw_addr_l);
                    wr_data.push_back(w_data_l);
                    case (aw_addr_l - BASE)
                        32'h4: reg_a = w_data_l;
                        32'h8: reg_b = w_data_l;
                        32'h0: if (w_data_l == 32'h1) begin
                            logic [31:0] x, y, t;
                            ctrl_reads = 0; x = reg_a; y = reg_b; reg_cnt = 0;
                            while (y != 0) begin t = x % y; x = y; y = t; reg_cnt++; end
                            reg_r = x;
                        end
                        default: ;
                    endcase
                end else if (got_aw && got_w && !bus.m_axi_bvalid) begin
                    bus.m_axi_bvalid = (b_wait >= b_dly);
                    bus.m_axi_bresp  = (aw_addr_l == err_addr) ? err_resp : 2'b00;
                    b_wait++;
                end
                if (r_hs) bus.m_axi_rvalid = 0;
                if (ar_hs) begin
                    bus.m_axi_arready = 0; bus.m_axi_rvalid = 1; bus.m_axi_rresp = 2'b00;
                    case (araddr_s - BASE)
                        32'h00: begin
                            ctrl_reads++;
                            bus.m_axi_rdata = (ready_after >= 0 && ctrl_reads > ready_after) ?
                                              32'h0000_0002 : 32'hFFFF_FFFD;
                        end
                        32'h0C:  bus.m_axi_rdata = reg_r;
                        32'h10:  bus.m_axi_rdata = reg_cnt;
                        default: bus.m_axi_rdata = 32'hDEAD_BEEF;
                    endcase
                end else if (bus.m_axi_arvalid && !bus.m_axi_arready && !bus.m_axi_rvalid) begin
                    bus.m_axi_arready = 1;
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        wr_addr.delete();
        wr_data.delete();
        while (bus.s_axis_tready !== 1'b1 && n < 200) begin @(posedge aclk); #1; n++; end
        check_eq("in_ready", bus.s_axis_tready, 1);
        bus.s_axis_tdata  = {b, a};
        bus.s_axis_tvalid = 1;
        @(posedge aclk); #1;
        bus.s_axis_tvalid = 0;
    endtask

    task automatic get_beat(input int stall, output logic [63:0] d, output logic u);
        int n = 0;
        while (bus.m_axis_tvalid !== 1'b1 && n < 2000) begin @(posedge aclk); #1; n++; end
        check_eq("out_valid", bus.m_axis_tvalid, 1);
        d = bus.m_axis_tdata;
        u = bus.m_axis_tuser;
        for (int i = 0; i < stall; i++) begin
            if (bus.s_axis_tready !== 1'b0) stall_viol++;
            @(posedge aclk); #1;
        end
        bus.m_axis_tready = 1;
        @(posedge aclk); #1;
        bus.m_axis_tready = 0;
        check_eq("beat_taken", {bus.m_axis_tvalid, bus.s_axis_tready}, 2'b01);
    endtask

    logic [63:0] d;
    logic        u;
    int          beats_before, n;

    initial begin
        #500_000;
        check_eq("watchdog", 0, 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn = 0; bus.s_axis_tvalid = 0; bus.s_axis_tdata = '0; bus.m_axis_tready = 0;
        repeat (3) @(posedge aclk);
        #1;
        check_eq("rst_outputs", {bus.s_axis_tready, bus.busy, bus.m_axis_tvalid, bus.m_axis_tuser,
                 bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_arvalid,
                 bus.m_axi_rready}, 9'h0);
        aresetn = 1;
        @(posedge aclk); #1;
        check_eq("rel_tready_busy", {bus.s_axis_tready, bus.busy}, 2'b10);

        // 48,18 with zero-wait slave: gcd 6 after 3 Euclid steps
        send(48, 18);
        get_beat(0, d, u);
        check_eq("t1_nwr", wr_addr.size(), 3);
        check_eq("t1_wr0", {wr_addr[0], wr_data[0]}, {BASE + 32'h4, 32'd48});
        check_eq("t1_wr1", {wr_addr[1], wr_data[1]}, {BASE + 32'h8, 32'd18});
        check_eq("t1_wr2", {wr_addr[2], wr_data[2]}, {BASE, 32'd1});
        check_eq("t1_r", d[31:0], 6);
        check_eq("t1_cnt", d[63:32], 3);
        check_eq("t1_user", u, 0);
        check_eq("t1_polls", ctrl_reads, 2);
        // arvalid rises GAP+1 edges after the edge of the START B handshake
        check_eq("t1_gap", t_ar - t_go, 3);
        check_eq("t1_wstrb", strb_viol, 0);

        // Stalled slave: awready 3 cycles ahead of wready, bvalid 5 late; 100,75 -> 25
        aw_dly = 1; w_dly = 4; b_dly = 5;
        send(100, 75);
        get_beat(0, d, u);
        check_eq("t2_r_cnt", d, {32'd2, 32'd25});
        check_eq("t2_user", u, 0);
        check_eq("t2_nwr", wr_addr.size(), 3);
        check_eq("t2_stable", stab_viol, 0);
        check_eq("t2_dup", dup_viol, 0);
        check_eq("t2_bready", bready_viol, 0);
        aw_dly = 0; w_dly = 0; b_dly = 0;

        // Output stalled 10 cycles; 35,14 -> 7
        send(35, 14);
        get_beat(10, d, u);
        check_eq("t3_r_cnt", d, {32'd2, 32'd7});
        check_eq("t3_in_ready_low", stall_viol, 0);
        check_eq("t3_stable", stab_viol, 0);

        // SLVERR on the B write: job still completes, flagged; 9,6 -> 3
        err_addr = BASE + 32'h8; err_resp = 2'b10;
        send(9, 6);
        get_beat(0, d, u);
        check_eq("t4_r_cnt", d, {32'd2, 32'd3});
        check_eq("t4_user", u, 1);
        check_eq("t4_nwr", wr_addr.size(), 3);
        err_addr = 32'hFFFF_FFFF; err_resp = 2'b00;

        // READY never set: exactly LIMIT CTRL reads, then timeout beat
        ready_after = -1;
        send(5, 10);
        get_beat(0, d, u);
        check_eq("t5_polls", ctrl_reads, 4);
        check_eq("t5_data", d, {32'hFFFF_FFFF, 32'h0});
        check_eq("t5_user", u, 1);

        // Reset while polling, then a fresh job 7,21 -> 7
        beats_before = beats;
        send(12, 8);
        n = 0;
        while (ctrl_reads < 2 && n < 300) begin @(posedge aclk); #1; n++; end
        check_eq("t6_in_poll", ctrl_reads >= 2, 1);
        aresetn = 0;
        @(posedge aclk); #1;
        check_eq("t6_rst_outputs", {bus.busy, bus.m_axis_tvalid, bus.m_axis_tuser, bus.s_axis_tready,
                 bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_arvalid,
                 bus.m_axi_rready}, 9'h0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1;
        @(posedge aclk); #1;
        check_eq("t6_rel_tready", bus.s_axis_tready, 1);
        ready_after = 1;
        send(7, 21);
        get_beat(0, d, u);
        check_eq("t6_beats", beats - beats_before, 1);
        check_eq("t6_first_wr", {wr_addr[0], wr_data[0]}, {BASE + 32'h4, 32'd7});
        check_eq("t6_r_cnt", d, {32'd2, 32'd7});
        check_eq("t6_user", u, 0);
        check_eq("overlap", overlap_viol, 0);
        check_eq("stable_all", stab_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
